// File: rtl/serial_uart_pkg.sv
// rtl/serial_uart_pkg.sv - shared frame constants and FSM state types for the UART bridge
package serial_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous show-ahead byte FIFO with push-on-full when popping
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop on empty is ignored; a push on full is only taken when a pop frees the slot
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// rtl/serial_uart_bridge.sv - FIFO-buffered 8N1 UART bridging the processor serial ports
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wren_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_rden_in,
  input  logic       err_clear_in,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out,
  output logic       tx_overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CPB_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(UART_STOP_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, tx_pop;
  logic [AW:0]   tx_count;
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end, tx_line_next;

  logic          rx_meta, rx_sync;
  logic          rx_full, rx_empty, rx_push, rx_frame_evt;
  logic [AW:0]   rx_count;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_bit_end;

  logic          tx_overflow_evt, rx_overrun_evt;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_wren_in),
    .push_data (tx_data_in),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_rden_in),
    .pop_data  (rx_data_out),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign tx_ready_out = (tx_count != FULL_COUNT);
  assign rx_valid_out = (rx_count != '0);

  // TX next state and the line level for the current state (registered one cycle later)
  always_comb begin
    tx_next      = tx_state;
    tx_pop       = 1'b0;
    tx_line_next = 1'b1;
    tx_bit_end   = (tx_cnt == CPB_LAST);
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_next = TX_START;
        end
      end
      TX_START: begin
        tx_line_next = 1'b0;
        if (tx_bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line_next = tx_shift[0];
        if (tx_bit_end && tx_idx == DATA_LAST) tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end && tx_idx == STOP_LAST) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX state, bit-period counter, bit index, shifter and registered line driver
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      uart_tx  <= tx_line_next;
      tx_cnt   <= (tx_state == TX_IDLE || tx_bit_end) ? '0 : tx_cnt + CW'(1);
      tx_idx   <= (tx_next != tx_state) ? '0 : (tx_bit_end ? tx_idx + 3'd1 : tx_idx);
      if (tx_pop) begin
        tx_shift <= tx_head;
      end else if (tx_state == TX_DATA && tx_bit_end) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
      end
    end
  end

  // Two-flop synchronizer for the asynchronous receive pin, idling high
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // RX next state; sample points land on the bit centres measured from the detected start edge
  always_comb begin
    rx_next      = rx_state;
    rx_bit_end   = 1'b0;
    rx_push      = 1'b0;
    rx_frame_evt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_bit_end = 1'b1;
          rx_next    = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CPB_LAST) begin
          rx_bit_end = 1'b1;
          if (rx_idx == DATA_LAST) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CPB_LAST) begin
          rx_bit_end = 1'b1;
          if (rx_sync) begin
            rx_push = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_frame_evt = 1'b1;
            rx_next      = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_sync) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // RX state, bit-period counter, bit index and LSB-first deserializer
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == RX_IDLE || rx_state == RX_BREAK || rx_bit_end) ? '0 : rx_cnt + CW'(1);
      rx_idx   <= (rx_next != rx_state) ? '0 : (rx_bit_end ? rx_idx + 3'd1 : rx_idx);
      if (rx_state == RX_DATA && rx_bit_end) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
    end
  end

  // A push into a full FIFO is only a loss when no pop frees a slot on the same edge
  assign tx_overflow_evt = tx_wren_in && tx_full && !tx_pop;
  assign rx_overrun_evt  = rx_push && rx_full && !(rx_rden_in && !rx_empty);

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
      tx_overflow_out  <= 1'b0;
    end else begin
      if (err_clear_in) begin
        rx_overrun_out   <= 1'b0;
        rx_frame_err_out <= 1'b0;
        tx_overflow_out  <= 1'b0;
      end
      if (rx_overrun_evt)  rx_overrun_out   <= 1'b1;
      if (rx_frame_evt)    rx_frame_err_out <= 1'b1;
      if (tx_overflow_evt) tx_overflow_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb/tb_serial_uart_bridge.sv - directed self-checking bench for serial_uart_bridge
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_wren_in = 1'b0;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_rden_in = 1'b0;
  logic       err_clear_in = 1'b0;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;
  logic       tx_overflow_out;

  int errors = 0;
  int checks = 0;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx          (uart_rx),
    .uart_tx          (uart_tx),
    .tx_data_in       (tx_data_in),
    .tx_wren_in       (tx_wren_in),
    .tx_ready_out     (tx_ready_out),
    .rx_data_out      (rx_data_out),
    .rx_valid_out     (rx_valid_out),
    .rx_rden_in       (rx_rden_in),
    .err_clear_in     (err_clear_in),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out),
    .tx_overflow_out  (tx_overflow_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected line level i cycles into a frame (i = 0 is the first start-bit cycle)
  function automatic logic tx_bit(input logic [7:0] b, input int i);
    if (i < CPB) return 1'b0;
    if (i < 9 * CPB) return b[(i - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic pop_rx();
    rx_rden_in = 1'b1;
    tick();
    rx_rden_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (tx_ready_out !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready_out); end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid_out); end
    checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_out); end
    checks++; if ({rx_overrun_out, rx_frame_err_out, tx_overflow_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {rx_overrun_out, rx_frame_err_out, tx_overflow_out});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_tx_byte();
    tx_data_in = 8'h55;
    tx_wren_in = 1'b1;
    tick();
    tx_wren_in = 1'b0;
    checks++; if (tx_ready_out !== 1'b1) begin errors++; $display("FAIL tx_ready_one_entry: got %b expected 1", tx_ready_out); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_edge_n: got %b expected 1", uart_tx); end
    tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_edge_n1: got %b expected 1", uart_tx); end
    tick();
    for (int i = 0; i < 10 * CPB; i++) begin
      checks++;
      if (uart_tx !== tx_bit(8'h55, i)) begin
        errors++; $display("FAIL tx_byte_cycle_%0d: got %b expected %b", i, uart_tx, tx_bit(8'h55, i));
      end
      tick();
    end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_idle_after_frame: got %b expected 1", uart_tx); end
    tick();
  endtask

  task automatic test_tx_backpressure();
    logic [7:0] bp [6];
    logic [5:0] exp_ready;
    logic [5:0] exp_ovf;
    logic       saw_low;
    bp[0] = 8'h01; bp[1] = 8'h80; bp[2] = 8'hC3;
    bp[3] = 8'h5A; bp[4] = 8'hFF; bp[5] = 8'h3C;
    exp_ready = 6'b001111;
    exp_ovf   = 6'b100000;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          tx_data_in = bp[k];
          tx_wren_in = 1'b1;
          tick();
          checks++; if (tx_ready_out !== exp_ready[k]) begin
            errors++; $display("FAIL bp_ready_push%0d: got %b expected %b", k, tx_ready_out, exp_ready[k]);
          end
          checks++; if (tx_overflow_out !== exp_ovf[k]) begin
            errors++; $display("FAIL bp_overflow_push%0d: got %b expected %b", k, tx_overflow_out, exp_ovf[k]);
          end
        end
        tx_wren_in = 1'b0;
      end
      begin
        repeat (3) tick();
        for (int f = 0; f < 5; f++) begin
          for (int i = 0; i < 10 * CPB + 1; i++) begin
            checks++;
            if (uart_tx !== tx_bit(bp[f], i)) begin
              errors++; $display("FAIL bp_frame%0d_cycle%0d: got %b expected %b", f, i, uart_tx, tx_bit(bp[f], i));
            end
            tick();
          end
        end
      end
    join
    checks++; if (tx_ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_drained: got %b expected 1", tx_ready_out); end
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL bp_dropped_byte_sent: got %b expected 0", saw_low); end
    err_clear_in = 1'b1;
    tick();
    err_clear_in = 1'b0;
    checks++; if (tx_overflow_out !== 1'b0) begin errors++; $display("FAIL bp_overflow_clear: got %b expected 0", tx_overflow_out); end
  endtask

  task automatic test_rx_frame();
    send_rx_frame(8'hA3, 1'b1);
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL rx_valid_before_stop: got %b expected 0", rx_valid_out); end
    tick();
    checks++; if (rx_valid_out !== 1'b1) begin errors++; $display("FAIL rx_valid_after_stop: got %b expected 1", rx_valid_out); end
    checks++; if (rx_data_out !== 8'hA3) begin errors++; $display("FAIL rx_data_a3: got %h expected a3", rx_data_out); end
    pop_rx();
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL rx_valid_after_pop: got %b expected 0", rx_valid_out); end
    tick();
  endtask

  task automatic test_rx_glitch_framing();
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (12) tick();
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL glitch_pushed: got %b expected 0", rx_valid_out); end
    checks++; if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", rx_frame_err_out); end
    send_rx_frame(8'h0F, 1'b0);
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (6) tick();
    checks++; if (rx_frame_err_out !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b expected 1", rx_frame_err_out); end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL frame_err_pushed: got %b expected 0", rx_valid_out); end
    send_rx_frame(8'h96, 1'b1);
    tick();
    checks++; if (rx_valid_out !== 1'b1) begin errors++; $display("FAIL good_after_break_valid: got %b expected 1", rx_valid_out); end
    checks++; if (rx_data_out !== 8'h96) begin errors++; $display("FAIL good_after_break_data: got %h expected 96", rx_data_out); end
    pop_rx();
    err_clear_in = 1'b1;
    tick();
    err_clear_in = 1'b0;
    checks++; if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b expected 0", rx_frame_err_out); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] exp_q [4];
    for (int i = 0; i < 5; i++) begin
      send_rx_frame(8'h11 * (i + 1), 1'b1);
      repeat (2) tick();
    end
    checks++; if (rx_overrun_out !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", rx_overrun_out); end
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_data_out !== exp_q[i]) begin errors++; $display("FAIL overrun_pop%0d: got %h expected %h", i, rx_data_out, exp_q[i]); end
      pop_rx();
    end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL overrun_drained: got %b expected 0", rx_valid_out); end
    err_clear_in = 1'b1;
    tick();
    err_clear_in = 1'b0;
    checks++; if (rx_overrun_out !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", rx_overrun_out); end

    for (int i = 0; i < 4; i++) begin
      send_rx_frame(8'h61 + 8'(i), 1'b1);
      repeat (2) tick();
    end
    send_rx_frame(8'h65, 1'b1);
    rx_rden_in = 1'b1;
    tick();
    rx_rden_in = 1'b0;
    checks++; if (rx_overrun_out !== 1'b0) begin errors++; $display("FAIL simul_no_overrun: got %b expected 0", rx_overrun_out); end
    exp_q[0] = 8'h62; exp_q[1] = 8'h63; exp_q[2] = 8'h64; exp_q[3] = 8'h65;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_data_out !== exp_q[i] || rx_valid_out !== 1'b1) begin
        errors++; $display("FAIL simul_pop%0d: got %h valid %b expected %h valid 1", i, rx_data_out, rx_valid_out, exp_q[i]);
      end
      pop_rx();
    end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL simul_count4: got valid %b expected 0", rx_valid_out); end
  endtask

  task automatic test_reset_mid_frame();
    logic saw_low;
    logic saw_valid;
    send_rx_frame(8'h5A, 1'b1);
    tick();
    uart_rx = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tx_data_in = 8'h00;
      tx_wren_in = 1'b1;
      tick();
    end
    tx_wren_in = 1'b0;
    repeat (8) tick();
    checks++; if ({uart_tx, rx_valid_out, tx_overflow_out} !== 3'b011) begin
      errors++; $display("FAIL pre_reset_state: got %b expected 011", {uart_tx, rx_valid_out, tx_overflow_out});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    uart_rx = 1'b1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_uart_tx: got %b expected 1", uart_tx); end
    checks++; if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL midreset_rx_valid: got %b expected 0", rx_valid_out); end
    checks++; if (tx_ready_out !== 1'b1) begin errors++; $display("FAIL midreset_tx_ready: got %b expected 1", tx_ready_out); end
    checks++; if (rx_data_out !== 8'h00) begin errors++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data_out); end
    checks++; if ({rx_overrun_out, rx_frame_err_out, tx_overflow_out} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags: got %b expected 000", {rx_overrun_out, rx_frame_err_out, tx_overflow_out});
    end
    saw_low = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      if (rx_valid_out !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL midreset_tx_fifo_empty: got %b expected 0", saw_low); end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midreset_rx_quiet: got %b expected 0", saw_valid); end
  endtask

  initial begin
    test_reset();
    test_tx_byte();
    test_tx_backpressure();
    test_rx_frame();
    test_rx_glitch_framing();
    test_rx_overrun();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
